// File: rtl/vppm_pkg.sv
// vppm_pkg: shared types and helpers for the VPPM transmitter.
// Holds the FSM state encoding, the preamble pattern used when the
// VPPM_PREAMBLE_EN build option is defined, and the symbol waveform function.
package vppm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic [7:0] PREAMBLE = 8'hAA;
  localparam int         PRE_LEN  = 8;

  // Output level of one VPPM symbol at position c: an early pulse carries a 0
  // and a late pulse carries a 1. Both are DUTY cycles wide.
  function automatic logic sym_level(input logic        b,
                                     input int unsigned c,
                                     input int unsigned sym_len,
                                     input int unsigned duty);
    if (b) return (c >= sym_len - duty);
    return (c < duty);
  endfunction

endpackage

// File: rtl/vppm_symbol_gen.sv
// vppm_symbol_gen: symbol position counter and registered VPPM waveform.
// The top supplies the next-cycle run flag and bit value. This block
// registers cnt, sym_tick and vppm_out so that all three line up with the
// cnt value they describe.
module vppm_symbol_gen
  import vppm_pkg::*;
#(
  parameter int SYM_LEN = 100,
  parameter int DUTY    = 50,
  parameter int CNT_W   = $clog2(SYM_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             run_d,
  input  logic             bit_d,
  output logic [CNT_W-1:0] cnt_d,
  output logic             sym_last,
  output logic             sym_tick,
  output logic             vppm_out
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SYM_LEN - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             sym_tick_q, sym_tick_d;
  logic             vppm_q, vppm_d;

  assign sym_last = (cnt_q == LAST);
  assign sym_tick = sym_tick_q;
  assign vppm_out = vppm_q;

  // Next counter position and the waveform value for that position.
  // A new frame always starts at position 0; the counter wraps at the symbol end.
  always_comb begin
    cnt_d = '0;
    if (run_d && !start && !sym_last) cnt_d = cnt_q + CNT_W'(1);
    sym_tick_d = run_d && (cnt_d == '0);
    vppm_d     = run_d && sym_level(bit_d, 32'(cnt_d), SYM_LEN, DUTY);
  end

  // Counter and output registers; the idle level of vppm_out is 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      sym_tick_q <= 1'b0;
      vppm_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sym_tick_q <= sym_tick_d;
      vppm_q     <= vppm_d;
    end
  end

endmodule

// File: rtl/vppm_tx.sv
// vppm_tx: VPPM transmitter. It accepts one word per valid/ready handshake
// and sends it MSB-first as fixed-width pulses whose position carries each bit.
// Build option VPPM_PREAMBLE_EN: prefix each frame with 8 symbols of
// 8'b10101010 so that the receiver can lock its symbol clock.
module vppm_tx
  import vppm_pkg::*;
#(
  parameter int SYM_LEN = 100,
  parameter int DUTY    = 50,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              vppm_out,
  output logic              sym_tick,
  output logic              tx_done
);

  localparam int CNT_W = $clog2(SYM_LEN);
  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SYM_LEN - 1);

  if (SYM_LEN < 2 || DUTY < 1 || DUTY >= SYM_LEN) begin : g_bad_param
    $error("vppm_tx: need SYM_LEN >= 2 and 1 <= DUTY <= SYM_LEN-1");
  end

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept, start, run_d, bit_d, sym_last;
  logic [CNT_W-1:0]  cnt_d;
`ifdef VPPM_PREAMBLE_EN
  logic [2:0]        pre_q, pre_d;
`endif

  assign accept   = tx_valid & ready_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

  vppm_symbol_gen #(
    .SYM_LEN (SYM_LEN),
    .DUTY    (DUTY),
    .CNT_W   (CNT_W)
  ) u_sym (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .run_d    (run_d),
    .bit_d    (bit_d),
    .cnt_d    (cnt_d),
    .sym_last (sym_last),
    .sym_tick (sym_tick),
    .vppm_out (vppm_out)
  );

  // Next-state logic: the handshake, frame sequencing and the bit to send next.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    start   = 1'b0;
`ifdef VPPM_PREAMBLE_EN
    pre_d   = pre_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          start   = 1'b1;
          shift_d = tx_data;
          idx_d   = IDX_W'(DATA_W - 1);
`ifdef VPPM_PREAMBLE_EN
          state_d = PRE;
          pre_d   = 3'd0;
`else
          state_d = DATA;
`endif
        end
      end
`ifdef VPPM_PREAMBLE_EN
      PRE: begin
        if (sym_last) begin
          if (pre_q == 3'(PRE_LEN - 1)) state_d = DATA;
          else                          pre_d   = pre_q + 3'd1;
        end
      end
`endif
      DATA: begin
        if (sym_last) begin
          if (idx_q == '0) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            shift_d = shift_q << 1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    run_d = (state_d != IDLE);
`ifdef VPPM_PREAMBLE_EN
    bit_d = (state_d == PRE) ? PREAMBLE[3'd7 - pre_d] : shift_d[DATA_W-1];
`else
    bit_d = shift_d[DATA_W-1];
`endif
    done_d  = (state_d == DATA) && (idx_d == '0) && (cnt_d == LAST);
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // FSM state, counters and registered handshake/status outputs.
  // A reset mid-frame drops the frame and emits no tx_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef VPPM_PREAMBLE_EN
      pre_q   <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef VPPM_PREAMBLE_EN
      pre_q   <= pre_d;
`endif
    end
  end

  // Shift register holding the word being sent.
  // It is data, so reset does not clear it.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule
